mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single-ported data/instruction SRAM shared by the IF stage and the MEM stage of the ARM pipeline. It accepts level-held requests from both stages and grants one at a time, MEM stage first. It drives the SRAM for a fixed number of wait cycles, captures read data and returns a one-cycle ready pulse to the granted requester. Pipeline freeze logic consumes the ready outputs to stall IF/ID or EXE/MEM until the access completes.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single-ported SRAM shared by the IF and MEM stages.
// MEM requests win over IF; each access holds the SRAM for WAIT_CYCLES and ends with a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 4,
    parameter int SRAM_AW     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_ready,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic               sram_we,
    output logic               sram_oe,
    input  logic [31:0]        sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_d;
    logic              grant_mem;
    logic              op_write;
    logic [CW-1:0]     cnt;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    wire mem_any = mem_r_en | mem_w_en;

    // Byte-lane and upper address bits are outside the SRAM word space.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                                mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // NOTE: next-state gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (mem_any || if_req) state_d = ACCESS;
            ACCESS:  if (cnt == '0)         state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_mem   <= 1'b0;
            op_write    <= 1'b0;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_any) begin
                        grant_mem <= 1'b1;
                        op_write  <= mem_w_en;
                        addr_q    <= mem_addr[SRAM_AW+1:2];
                        wdata_q   <= mem_wdata;
                        cnt       <= CNT_INIT;
                    end else if (if_req) begin
                        grant_mem <= 1'b0;
                        op_write  <= 1'b0;
                        addr_q    <= if_addr[SRAM_AW+1:2];
                        cnt       <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Read data is valid only at the edge closing the final wait cycle.
                        if (!op_write) begin
                            if (grant_mem) mem_rdata_q <= sram_rdata;
                            else           if_rdata_q  <= sram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from registered state only, never from the request inputs.
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we    = (state == ACCESS) &&  op_write;
    assign sram_oe    = (state == ACCESS) && !op_write;
    assign if_ready   = (state == RESP)   && !grant_mem;
    assign mem_ready  = (state == RESP)   &&  grant_mem;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM model.
// Cycle 0 is the IDLE cycle in which a request is first presented.
module tb_mem_port_arbiter;

    localparam int WAIT_CYCLES = 4;
    localparam int SRAM_AW     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               if_req;
    logic [31:0]        if_addr;
    logic [31:0]        if_rdata;
    logic               if_ready;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic               sram_we;
    logic               sram_oe;
    logic [31:0]        sram_rdata;

    int compared   = 0;
    int mismatched = 0;

    // SRAM model; preload port lets the bench seed words without a second writer process.
    logic [31:0] sram_mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (sram_we)     sram_mem[sram_addr[9:0]] <= sram_wdata;
        else if (pre_we) sram_mem[pre_addr]       <= pre_data;
    end
    assign sram_rdata = sram_mem[sram_addr[9:0]];

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .sram_rdata (sram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are stable here.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = '0; mem_wdata = '0;
        pre_we = 1'b1; pre_addr = 10'd4; pre_data = 32'hE3A0_1005;
        tick(2);
        pre_we = 1'b0;
        check("rst_we",        {31'd0, sram_we},   32'd0);
        check("rst_oe",        {31'd0, sram_oe},   32'd0);
        check("rst_addr",      {16'd0, sram_addr}, 32'd0);
        check("rst_wdata",     sram_wdata,         32'd0);
        check("rst_if_ready",  {31'd0, if_ready},  32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_if_rdata",  if_rdata,           32'd0);
        check("rst_mem_rdata", mem_rdata,          32'd0);
        rst = 1'b0;
        tick(1);

        // Single IF read of word 4; address change mid-access must be ignored.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        check("if_c0_oe", {31'd0, sram_oe}, 32'd0);
        for (int c = 1; c <= WAIT_CYCLES; c++) begin
            tick(1);
            if (c == 2) if_addr = 32'h0000_0020;
            check($sformatf("if_c%0d_oe", c),    {31'd0, sram_oe},   32'd1);
            check($sformatf("if_c%0d_we", c),    {31'd0, sram_we},   32'd0);
            check($sformatf("if_c%0d_addr", c),  {16'd0, sram_addr}, 32'd4);
            check($sformatf("if_c%0d_ready", c), {31'd0, if_ready},  32'd0);
        end
        tick(1);
        check("if_c5_ready", {31'd0, if_ready}, 32'd1);
        check("if_c5_rdata", if_rdata,          32'hE3A0_1005);
        check("if_c5_oe",    {31'd0, sram_oe},  32'd0);
        tick(1);
        if_req = 1'b0;
        check("if_c6_ready", {31'd0, if_ready}, 32'd0);

        // MEM store to 0x400, then load back.
        mem_w_en = 1'b1; mem_addr = 32'h0000_0400; mem_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= WAIT_CYCLES; c++) begin
            tick(1);
            check($sformatf("st_c%0d_we", c),    {31'd0, sram_we},   32'd1);
            check($sformatf("st_c%0d_oe", c),    {31'd0, sram_oe},   32'd0);
            check($sformatf("st_c%0d_addr", c),  {16'd0, sram_addr}, 32'h100);
            check($sformatf("st_c%0d_wdata", c), sram_wdata,         32'hDEAD_BEEF);
        end
        tick(1);
        check("st_c5_ready", {31'd0, mem_ready}, 32'd1);
        check("st_c5_we",    {31'd0, sram_we},   32'd0);
        tick(1);
        mem_w_en = 1'b0; mem_r_en = 1'b1;
        tick(1);
        check("ld_c1_oe", {31'd0, sram_oe}, 32'd1);
        tick(3);
        check("ld_c4_ready", {31'd0, mem_ready}, 32'd0);
        tick(1);
        check("ld_c5_ready", {31'd0, mem_ready}, 32'd1);
        check("ld_c5_rdata", mem_rdata,          32'hDEAD_BEEF);
        tick(1);
        mem_r_en = 1'b0;

        // Simultaneous IF and MEM requests: MEM first, IF regranted at cycle 6.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        mem_r_en = 1'b1; mem_addr = 32'h0000_0400;
        tick(1);
        check("pri_c1_addr", {16'd0, sram_addr}, 32'h100);
        tick(4);
        check("pri_c5_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("pri_c5_if_ready",  {31'd0, if_ready},  32'd0);
        tick(1);
        mem_r_en = 1'b0;
        check("pri_c6_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick(1);
        check("pri_c7_addr", {16'd0, sram_addr}, 32'd4);
        check("pri_c7_oe",   {31'd0, sram_oe},   32'd1);
        tick(3);
        check("pri_c10_if_ready", {31'd0, if_ready}, 32'd0);
        tick(1);
        check("pri_c11_if_ready", {31'd0, if_ready}, 32'd1);
        check("pri_c11_if_rdata", if_rdata,          32'hE3A0_1005);
        tick(1);
        if_req = 1'b0;

        // Read and write both high: performed as a write, mem_rdata untouched.
        mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h0000_0404; mem_wdata = 32'h1234_5678;
        tick(1);
        check("rw_c1_we",   {31'd0, sram_we},   32'd1);
        check("rw_c1_oe",   {31'd0, sram_oe},   32'd0);
        check("rw_c1_addr", {16'd0, sram_addr}, 32'h101);
        tick(3);
        check("rw_c4_oe", {31'd0, sram_oe}, 32'd0);
        tick(1);
        check("rw_c5_ready", {31'd0, mem_ready}, 32'd1);
        check("rw_c5_rdata", mem_rdata,          32'hDEAD_BEEF);
        tick(1);
        mem_r_en = 1'b0; mem_w_en = 1'b0;

        // Reset in cycle 2 of an IF read aborts it; held request restarts fully.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        tick(1);
        check("ab_c1_oe", {31'd0, sram_oe}, 32'd1);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("ab_c3_oe",    {31'd0, sram_oe},   32'd0);
        check("ab_c3_ready", {31'd0, if_ready},  32'd0);
        check("ab_c3_addr",  {16'd0, sram_addr}, 32'd0);
        check("ab_c3_rdata", if_rdata,           32'd0);
        rst = 1'b0;
        tick(1);
        check("ab_c4_oe",   {31'd0, sram_oe},   32'd1);
        check("ab_c4_addr", {16'd0, sram_addr}, 32'd4);
        tick(3);
        check("ab_c7_ready", {31'd0, if_ready}, 32'd0);
        tick(1);
        check("ab_c8_ready", {31'd0, if_ready}, 32'd1);
        check("ab_c8_rdata", if_rdata,          32'hE3A0_1005);
        tick(1);
        if_req = 1'b0;
        check("ab_c9_ready", {31'd0, if_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
